// File: rtl/status_flags_pkg.sv
// Shared definitions for the 65C02 processor status register (P).
// Flag bit positions inside P, flag_op encodings and the default reset image.
// No logic here; imported by status_flags and flag_pend.
package status_flags_pkg;

   // Bit positions inside P: N V 1 B D I Z C
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_I = 2;
   localparam int FLAG_D = 3;
   localparam int FLAG_B = 4;
   localparam int FLAG_U = 5;
   localparam int FLAG_V = 6;
   localparam int FLAG_N = 7;

   // Bits 5 and 4 of the live P always read as 1
   localparam logic [7:0] P_FIXED = 8'((1 << FLAG_U) | (1 << FLAG_B));

   localparam logic [7:0] RESET_P_DEFAULT = 8'h34;

   typedef enum logic [2:0] {
      FOP_NONE = 3'd0,
      FOP_CLC  = 3'd1,
      FOP_SEC  = 3'd2,
      FOP_CLI  = 3'd3,
      FOP_SEI  = 3'd4,
      FOP_CLD  = 3'd5,
      FOP_SED  = 3'd6,
      FOP_CLV  = 3'd7
   } flag_op_e;

endpackage

// File: rtl/status_flags_flag_pend.sv
// Pending ALU flag update stage: remembers which flags the issued op writes.
// Latency: mask loads on the issue edge, apply enables are live the next RDY cycle.
// Backpressure: RDY low freezes the mask and suppresses all apply enables.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   rdy             global ready; qualifies every state change
//   alu_issue       ALU op issued this cycle
//   upd_mask        flags the issued op updates [3]=N [2]=V [1]=Z [0]=C
//   alu_co          ALU carry-out (valid the cycle after issue)
//   p_c             current registered carry flag
//   apply           per-flag apply enable for this cycle
//   ci              carry-in to the ALU, forwarded from alu_co when pending
module flag_pend
   import status_flags_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rdy,
   input  logic       alu_issue,
   input  logic [3:0] upd_mask,
   input  logic       alu_co,
   input  logic       p_c,
   output logic [3:0] apply,
   output logic       ci
);

   logic [3:0] pend_mask;

   // Reloaded on the same edge it is consumed, so back-to-back ops need no bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_mask <= '0;
      end else if (rdy) begin
         pend_mask <= alu_issue ? upd_mask : 4'b0000;
      end
   end

   assign apply = pend_mask & {4{rdy}};

   // The carry the ALU is about to write is not in P yet; forward it so
   // ADC;ADC chains see the fresh value.
   assign ci = pend_mask[0] ? alu_co : p_c;

endmodule

// File: rtl/status_flags.sv
// 65C02 processor status register fed by the registered ALU flags and flag ops.
// Latency: ALU flags appear on P two RDY edges after issue; direct loads one edge.
// Backpressure: RDY low holds P and the pending update; reset overrides RDY.
//
// Optional build macro CMOS_DCLEAR_EN: when defined, irq_take also clears D
// (65C02 behaviour, beats SED); when undefined D is untouched by irq_take.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   RDY                   global ready
//   alu_issue, upd_mask   ALU issue strobe and flags it will update
//   alu_co/v/z/n          ALU flags, valid the cycle after issue
//   plp, bit_ld, din      P load from bus / BIT N,V load, data bus
//   flag_op               SEx/CLx encoding (see status_flags_pkg)
//   irq_take              interrupt/BRK entry, sets I
//   adc_sbc, brk_push     ADC/SBC in progress, B bit for the pushed image
//   P, p_push             live status and stack image
//   ci, bcd               carry-in and decimal enable to the ALU
module status_flags
   import status_flags_pkg::*;
#(
   parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RDY,
   input  logic       alu_issue,
   input  logic [3:0] upd_mask,
   input  logic       alu_co,
   input  logic       alu_v,
   input  logic       alu_z,
   input  logic       alu_n,
   input  logic       plp,
   input  logic       bit_ld,
   input  logic [7:0] din,
   input  logic [2:0] flag_op,
   input  logic       irq_take,
   input  logic       adc_sbc,
   input  logic       brk_push,
   output logic [7:0] P,
   output logic [7:0] p_push,
   output logic       ci,
   output logic       bcd
);

   logic [7:0] p_q;
   logic [7:0] p_nxt;
   logic [3:0] apply;

   flag_pend u_flag_pend (
      .clk       (clk),
      .reset     (reset),
      .rdy       (RDY),
      .alu_issue (alu_issue),
      .upd_mask  (upd_mask),
      .alu_co    (alu_co),
      .p_c       (p_q[FLAG_C]),
      .apply     (apply),
      .ci        (ci)
   );

   // Sources are layered lowest priority first so later writes win per bit.
   always_comb begin
      p_nxt = p_q;

      if (apply[0]) p_nxt[FLAG_C] = alu_co;
      if (apply[1]) p_nxt[FLAG_Z] = alu_z;
      if (apply[2]) p_nxt[FLAG_V] = alu_v;
      if (apply[3]) p_nxt[FLAG_N] = alu_n;

      // BIT overrides a pending ALU write for N and V only; Z still comes
      // from the ALU.
      if (bit_ld) begin
         p_nxt[FLAG_N] = din[7];
         p_nxt[FLAG_V] = din[6];
      end

      case (flag_op_e'(flag_op))
         FOP_NONE: ;
         FOP_CLC:  p_nxt[FLAG_C] = 1'b0;
         FOP_SEC:  p_nxt[FLAG_C] = 1'b1;
         FOP_CLI:  p_nxt[FLAG_I] = 1'b0;
         FOP_SEI:  p_nxt[FLAG_I] = 1'b1;
         FOP_CLD:  p_nxt[FLAG_D] = 1'b0;
         FOP_SED:  p_nxt[FLAG_D] = 1'b1;
         FOP_CLV:  p_nxt[FLAG_V] = 1'b0;
         default:  ;
      endcase

      if (irq_take) begin
         p_nxt[FLAG_I] = 1'b1;
`ifdef CMOS_DCLEAR_EN
         p_nxt[FLAG_D] = 1'b0;
`endif
      end

      // PLP/RTI replaces everything; bits 5/4 of the bus are ignored by
      // forcing them to 1, which also keeps the register image canonical.
      if (plp) p_nxt = din | P_FIXED;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_q <= RESET_P | P_FIXED;
      end else if (RDY) begin
         p_q <= p_nxt;
      end
   end

   assign P = p_q;

   always_comb begin
      p_push         = p_q;
      p_push[FLAG_B] = brk_push;
   end

   assign bcd = p_q[FLAG_D] & adc_sbc;

endmodule

// File: tb/tb_status_flags.sv
module tb_status_flags;

   logic       clk = 1'b0;
   logic       reset, RDY, alu_issue;
   logic [3:0] upd_mask;
   logic       alu_co, alu_v, alu_z, alu_n;
   logic       plp, bit_ld;
   logic [7:0] din;
   logic [2:0] flag_op;
   logic       irq_take, adc_sbc, brk_push;
   logic [7:0] P, p_push;
   logic       ci, bcd;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef CMOS_DCLEAR_EN
   localparam bit CMOS = 1'b1;
`else
   localparam bit CMOS = 1'b0;
`endif

   // Reference model state: architectural P and which flags the ALU still owes
   logic [7:0] m_p;
   logic [3:0] m_pend;
   bit         m_valid = 1'b0;

   // flag_op table: target bit of P and the value written
   int fop_bit [8] = '{-1, 0, 0, 2, 2, 3, 3, 6};
   bit fop_val [8] = '{ 0, 0, 1, 0, 1, 0, 1, 0};

   status_flags dut (
      .clk(clk), .reset(reset), .RDY(RDY), .alu_issue(alu_issue),
      .upd_mask(upd_mask), .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z),
      .alu_n(alu_n), .plp(plp), .bit_ld(bit_ld), .din(din),
      .flag_op(flag_op), .irq_take(irq_take), .adc_sbc(adc_sbc),
      .brk_push(brk_push), .P(P), .p_push(p_push), .ci(ci), .bcd(bcd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      reset = 0; RDY = 1; alu_issue = 0; upd_mask = 0;
      alu_co = 0; alu_v = 0; alu_z = 0; alu_n = 0;
      plp = 0; bit_ld = 0; din = 0; flag_op = 0;
      irq_take = 0; adc_sbc = 0; brk_push = 0;
   endtask

   // Next P from the rules: each flag takes the highest-ranked source that
   // addresses it (0 plp, 1 irq, 2 flag_op, 3 bit_ld, 4 pending ALU).
   task automatic model_step();
      logic [7:0] np;
      logic [3:0] alu_vals;
      bit sh [5];
      bit sv [5];
      int pi;
      if (reset) begin
         m_p = 8'h34 | 8'h30;
         m_pend = 4'b0;
         m_valid = 1'b1;
         return;
      end
      if (!RDY) return;
      alu_vals = {alu_n, alu_v, alu_z, alu_co};
      np = m_p;
      for (int b = 0; b < 8; b++) begin
         if (b == 4 || b == 5) continue;
         pi = (b == 0) ? 0 : (b == 1) ? 1 : (b == 6) ? 2 : (b == 7) ? 3 : -1;
         sh[0] = plp;                                   sv[0] = din[b];
         sh[1] = irq_take && (b == 2 || (CMOS && b == 3)); sv[1] = (b == 2);
         sh[2] = (fop_bit[flag_op] == b);               sv[2] = fop_val[flag_op];
         sh[3] = bit_ld && (b == 6 || b == 7);          sv[3] = din[b];
         sh[4] = (pi >= 0) && m_pend[pi];               sv[4] = (pi >= 0) ? alu_vals[pi] : 1'b0;
         for (int s = 0; s < 5; s++) begin
            if (sh[s]) begin
               np[b] = sv[s];
               break;
            end
         end
      end
      m_p = np;
      m_pend = alu_issue ? upd_mask : 4'b0;
   endtask

   // Called just after a falling edge with inputs already driven
   task automatic tick();
      logic [7:0] exp_push;
      #1;
      if (m_valid) begin
         chk("ci_fwd", {7'b0, ci}, {7'b0, (m_pend[0] ? alu_co : m_p[0])});
         chk("bcd", {7'b0, bcd}, {7'b0, m_p[3] & adc_sbc});
         exp_push = {m_p[7:6], 1'b1, brk_push, m_p[3:0]};
         chk("p_push", p_push, exp_push);
      end
      @(posedge clk);
      model_step();
      #1;
      chk("P_model", P, m_p);
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      @(negedge clk);

      // Reset with RDY low still takes effect
      reset = 1; RDY = 0; adc_sbc = 1;
      tick();
      chk("reset_P", P, 8'h34);
      #1;
      chk("reset_ci", {7'b0, ci}, 8'h00);
      chk("reset_bcd", {7'b0, bcd}, 8'h00);

      // ADC then ADC: carry forwarded to the second op, then visible on P
      clear_inputs();
      alu_issue = 1; upd_mask = 4'b1111;
      tick();
      alu_co = 1;
      #1;
      chk("adc_ci_forward", {7'b0, ci}, 8'h01);
      tick();
      chk("adc_P_C", {7'b0, P[0]}, 8'h01);
      alu_issue = 0; alu_co = 0;
      tick();
      chk("adc2_P_C", {7'b0, P[0]}, 8'h00);

      // Stall with a pending Z update
      alu_issue = 1; upd_mask = 4'b0010;
      tick();
      alu_issue = 0; RDY = 0; alu_z = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold_Z", {7'b0, P[1]}, 8'h00);
      end
      RDY = 1;
      tick();
      chk("stall_apply_Z", {7'b0, P[1]}, 8'h01);

      // PLP collides with a full pending update
      alu_issue = 1; upd_mask = 4'b1111; alu_z = 0;
      tick();
      alu_issue = 0; plp = 1; din = 8'hC3;
      alu_co = 0; alu_v = 0; alu_z = 0; alu_n = 0;
      tick();
      chk("plp_collision", P, 8'hF3);
      plp = 0; din = 0;

      // BIT with pending Z (and V/N pending too: BIT wins those)
      alu_issue = 1; upd_mask = 4'b1110;
      tick();
      alu_issue = 0; bit_ld = 1; din = 8'h80; alu_z = 1; alu_v = 1; alu_n = 0;
      tick();
      chk("bit_N", {7'b0, P[7]}, 8'h01);
      chk("bit_V", {7'b0, P[6]}, 8'h00);
      chk("bit_Z", {7'b0, P[1]}, 8'h01);
      clear_inputs();

      // CLC alongside a pending Z: both land
      alu_issue = 1; upd_mask = 4'b0010;
      tick();
      alu_issue = 0; flag_op = 3'd1; alu_z = 0;
      tick();
      chk("clc_C", {7'b0, P[0]}, 8'h00);
      chk("clc_Z", {7'b0, P[1]}, 8'h00);
      clear_inputs();

      // Interrupt entry with D set; SED in the same cycle
      flag_op = 3'd6; flag_op = 3'd6;
      tick();
      adc_sbc = 1;
      #1;
      chk("sed_bcd", {7'b0, bcd}, 8'h01);
      irq_take = 1; brk_push = 1;
      #1;
      chk("brk_push_B", {7'b0, p_push[4]}, 8'h01);
      tick();
      chk("irq_I", {7'b0, P[2]}, 8'h01);
      chk("irq_D", {7'b0, P[3]}, CMOS ? 8'h00 : 8'h01);
      brk_push = 0;
      #1;
      chk("push_B0", {7'b0, p_push[4]}, 8'h00);
      chk("live_B", {7'b0, P[4]}, 8'h01);
      clear_inputs();
      // SED vs irq_take
      flag_op = 3'd5;
      tick();
      flag_op = 3'd6; irq_take = 1;
      tick();
      chk("irq_vs_sed_D", {7'b0, P[3]}, CMOS ? 8'h00 : 8'h01);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         reset     = ($urandom_range(0, 99) < 2);
         RDY       = ($urandom_range(0, 99) < 80);
         alu_issue = ($urandom_range(0, 99) < 60);
         upd_mask  = 4'($urandom);
         {alu_co, alu_v, alu_z, alu_n} = 4'($urandom);
         plp       = ($urandom_range(0, 99) < 8);
         bit_ld    = ($urandom_range(0, 99) < 12);
         din       = 8'($urandom);
         flag_op   = ($urandom_range(0, 99) < 40) ? 3'($urandom) : 3'd0;
         irq_take  = ($urandom_range(0, 99) < 8);
         adc_sbc   = 1'($urandom);
         brk_push  = 1'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
